fw_ip2_cfg_shift_ctrl: RTL and testbench
========================================

# fw_ip2_cfg_shift_ctrl

Configuration-chain sequencer for the fw_ip2 firmware slot. It buffers software-written 24-bit configuration words and, on an execute op-code, shifts them serially into the DUT configuration chain on `fw_config_clk`/`fw_config_in`, then pulses `fw_config_load`. While shifting it captures the bits returned on `fw_config_out` into a readback buffer. It sits between the op-code decoder outputs and the DUT-side pins, and supplies `fw_read_data32` and `fw_read_status32` back to software.

## Interface
- `CFG_WORDS`, 32: depth of the write and readback buffers, in 24-bit words; chain length is at most CFG_WORDS*24 bits.
- `PTR_W`, 5: pointer width, $clog2(CFG_WORDS).

- `fw_clk_100`  in  1  sole clock; all logic is on its rising edge.
- `fw_rst`  in  1  reset, synchronous, active-high.
- `op_code_w_reset`  in  1  soft-reset pulse; same effect as `fw_rst`.
- `op_code_w_cfg_static_0`  in  1  write pulse for the static register: `sw_write24_0[15:0]` = NBITS, `[23:16]` = DIV (half-period of `fw_config_clk`, in clocks).
- `op_code_r_cfg_static_0`  in  1  read pulse; returns {8'h0, static register}.
- `op_code_w_cfg_array_0`  in  1  write `sw_write24_0` to write buffer[wr_ptr], then wr_ptr++.
- `op_code_r_cfg_array_0`  in  1  read readback buffer[rd_ptr], then rd_ptr++.
- `op_code_w_execute`  in  1  start a shift sequence.
- `sw_write24_0`  in  24  write payload.
- `fw_read_data32`  out  32  registered read data.
- `fw_read_status32`  out  32  registered status, continuously updated.
- `fw_config_clk`  out  1  chain clock.
- `fw_config_in`  out  1  chain serial data.
- `fw_config_load`  out  1  chain load strobe.
- `fw_config_out`  in  1  chain serial return.

## Operation
- Op-code inputs are single-cycle pulses, with at most one asserted per cycle. Priority if several assert: reset > execute > writes > reads.
- Reset (`fw_rst` or `op_code_w_reset`):
  - State goes to IDLE.
  - All outputs go to 0.
  - wr_ptr, rd_ptr, the bit counter and the done/err flags clear.
  - Static register resets to NBITS=0, DIV=1.
  - Buffer contents are not cleared.
- DIV=0 is treated as 1. NBITS greater than CFG_WORDS*24 is clamped to CFG_WORDS*24.
- Bit i of the chain is write buffer word i/24, bit i%24. Bits are sent LSB first, starting from word 0.
- FSM states: IDLE, SH_LO, SH_HI, LOAD.
  - IDLE + execute with NBITS>0: bit counter=0, done=0, go to SH_LO.
  - IDLE + execute with NBITS=0: done=1, stay in IDLE, no load pulse.
  - SH_LO: `fw_config_clk`=0 and `fw_config_in`=bit[cnt] for DIV cycles, then go to SH_HI.
  - On the SH_LO→SH_HI edge, sample `fw_config_out` into readback bit[cnt].
  - SH_HI: `fw_config_clk`=1 for DIV cycles. Then cnt++ and go to SH_LO, or go to LOAD if cnt = NBITS-1.
  - LOAD: `fw_config_clk`=0 and `fw_config_load`=1 for DIV cycles, then done=1 and go to IDLE.
- While busy (any state other than IDLE), execute, w_cfg_array_0 and w_cfg_static_0 are ignored and set err (sticky).
- Reads are serviced in any state.
- wr_ptr and rd_ptr wrap from CFG_WORDS-1 to 0. Execute resets rd_ptr to 0; wr_ptr is unaffected.
- fw_read_status32 layout:
  - [0] busy
  - [1] done
  - [2] err
  - [7:3] 0
  - [15:8] wr_ptr (zero-extended)
  - [31:16] bit counter

## Timing
- All outputs are registered.
- Execute sampled at edge T:
  - busy=1 and `fw_config_in`=bit0 from T+1.
  - First `fw_config_clk` rise at T+1+DIV.
  - `fw_config_load` high from T+1+2·DIV·NBITS for DIV cycles.
  - busy=0 and done=1 at T+1+(2·NBITS+1)·DIV.
- Read pulse at T: `fw_read_data32` is valid at T+1 and holds until the next read.
- A write at T is visible in status at T+1.
- Reset mid-sequence: at the next edge, `fw_config_clk`, `fw_config_in` and `fw_config_load` are 0 and the FSM is in IDLE. The partial load pulse is truncated, not completed.

## Test plan
- Reset then idle: all outputs 0, status=32'h0000_0000; r_cfg_static_0 returns 32'h0001_0000 (DIV=1, NBITS=0).
- Static write 24'h02_0030 (DIV=2, NBITS=48), then words 24'hA5A5A5 and 24'h3C3C3C, execute:
  - `fw_config_in` sequence is 1,0,1,0,0,1,0,1… LSB first.
  - Config clock period is 4 cycles.
  - Load is high for 2 cycles, and done asserts at T+1+194.
- Loopback `fw_config_out`=`fw_config_in` delayed by one chain bit, with NBITS=24 and word0=24'h000001: the readback first read returns 32'h0000_0002.
- Execute or array write during busy: the sequence is unchanged, err=1, and wr_ptr is unchanged; err clears only on reset.
- Write 33 words with CFG_WORDS=32: wr_ptr wraps to 1, word 0 is overwritten, and status[15:8]=8'h01. Static NBITS=16'hFFFF is clamped to 768 shifted bits.
- `op_code_w_reset` mid-SH_HI: the clock drops to 0 the next cycle, busy=0, done=0, and the counter is 0.

Source files
------------

// File: rtl/fw_ip2_cfg_shift_ctrl.sv
// Configuration-chain sequencer for the fw_ip2 slot: buffers 24-bit config words,
// shifts them LSB-first into the DUT chain, pulses load, and captures the return
// stream into a readback buffer for software.
module fw_ip2_cfg_shift_ctrl #(
    parameter int unsigned CFG_WORDS = 32,
    parameter int unsigned PTR_W     = 5
) (
    input  logic        fw_clk_100,
    input  logic        fw_rst,
    input  logic        op_code_w_reset,
    input  logic        op_code_w_cfg_static_0,
    input  logic        op_code_r_cfg_static_0,
    input  logic        op_code_w_cfg_array_0,
    input  logic        op_code_r_cfg_array_0,
    input  logic        op_code_w_execute,
    input  logic [23:0] sw_write24_0,
    output logic [31:0] fw_read_data32,
    output logic [31:0] fw_read_status32,
    output logic        fw_config_clk,
    output logic        fw_config_in,
    output logic        fw_config_load,
    input  logic        fw_config_out
);

    localparam logic [15:0]      MAX_BITS = 16'(CFG_WORDS * 24);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CFG_WORDS - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = '0;

    typedef enum logic [1:0] {StIdle, StShLo, StShHi, StLoad} state_e;

    state_e           state_q;
    logic [15:0]      nbits_q;
    logic [7:0]       div_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [15:0]      cnt_q;
    logic [PTR_W-1:0] word_q;
    logic [4:0]       bit_q;
    logic [7:0]       tmr_q;
    logic             busy_q, done_q, err_q;
    logic             cfg_clk_q, cfg_in_q, cfg_load_q;
    logic [31:0]      rdata_q;

    logic [23:0] wbuf [CFG_WORDS];
    logic [23:0] rbuf [CFG_WORDS];

    logic             rst_any, tmr_last, last_bit, any_write, wb_we, rb_we;
    logic [7:0]       div_eff;
    logic [15:0]      nbits_eff;
    logic [4:0]       next_bit;
    logic [PTR_W-1:0] next_word;

    // Effective timing/length and the chain position of the following bit.
    always_comb begin
        rst_any   = fw_rst | op_code_w_reset;
        div_eff   = (div_q == 8'd0) ? 8'd1 : div_q;
        nbits_eff = (nbits_q > MAX_BITS) ? MAX_BITS : nbits_q;
        tmr_last  = (tmr_q == div_eff - 8'd1);
        last_bit  = (cnt_q == nbits_eff - 16'd1);
        any_write = op_code_w_execute | op_code_w_cfg_array_0 | op_code_w_cfg_static_0;
        next_bit  = (bit_q == 5'd23) ? 5'd0 : bit_q + 5'd1;
        next_word = word_q;
        if (bit_q == 5'd23) begin
            next_word = (word_q == PTR_LAST) ? PTR_ZERO : word_q + PTR_W'(1);
        end
        wb_we = !rst_any && !op_code_w_execute && (state_q == StIdle) && op_code_w_cfg_array_0;
        rb_we = !rst_any && (state_q == StShLo) && tmr_last;
    end

    // Buffer storage; contents deliberately survive reset.
    always_ff @(posedge fw_clk_100) begin
        if (wb_we) begin
            wbuf[wr_ptr_q] <= sw_write24_0;
        end
        if (rb_we) begin
            rbuf[word_q][bit_q] <= fw_config_out;
        end
    end

    // Op-code decode, shift sequencer and registered outputs.
    always_ff @(posedge fw_clk_100) begin
        if (rst_any) begin
            state_q    <= StIdle;
            nbits_q    <= 16'd0;
            div_q      <= 8'd1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= 16'd0;
            word_q     <= '0;
            bit_q      <= 5'd0;
            tmr_q      <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cfg_clk_q  <= 1'b0;
            cfg_in_q   <= 1'b0;
            cfg_load_q <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            if (any_write) begin
                if (state_q != StIdle) begin
                    err_q <= 1'b1;
                end else if (op_code_w_execute) begin
                    rd_ptr_q <= '0;
                    if (nbits_eff == 16'd0) begin
                        done_q <= 1'b1;
                    end else begin
                        state_q   <= StShLo;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        cnt_q     <= 16'd0;
                        word_q    <= '0;
                        bit_q     <= 5'd0;
                        tmr_q     <= 8'd0;
                        cfg_clk_q <= 1'b0;
                        cfg_in_q  <= wbuf[PTR_ZERO][0];
                    end
                end else begin
                    if (op_code_w_cfg_static_0) begin
                        nbits_q <= sw_write24_0[15:0];
                        div_q   <= sw_write24_0[23:16];
                    end
                    if (op_code_w_cfg_array_0) begin
                        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? PTR_ZERO : wr_ptr_q + PTR_W'(1);
                    end
                end
            end else if (op_code_r_cfg_static_0) begin
                rdata_q <= {8'h00, div_q, nbits_q};
            end else if (op_code_r_cfg_array_0) begin
                rdata_q  <= {8'h00, rbuf[rd_ptr_q]};
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? PTR_ZERO : rd_ptr_q + PTR_W'(1);
            end

            unique case (state_q)
                StShLo: begin
                    if (tmr_last) begin
                        tmr_q     <= 8'd0;
                        cfg_clk_q <= 1'b1;
                        state_q   <= StShHi;
                    end else begin
                        tmr_q <= tmr_q + 8'd1;
                    end
                end
                StShHi: begin
                    if (tmr_last) begin
                        tmr_q     <= 8'd0;
                        cfg_clk_q <= 1'b0;
                        if (last_bit) begin
                            state_q    <= StLoad;
                            cfg_in_q   <= 1'b0;
                            cfg_load_q <= 1'b1;
                        end else begin
                            state_q  <= StShLo;
                            cnt_q    <= cnt_q + 16'd1;
                            word_q   <= next_word;
                            bit_q    <= next_bit;
                            cfg_in_q <= wbuf[next_word][next_bit];
                        end
                    end else begin
                        tmr_q <= tmr_q + 8'd1;
                    end
                end
                StLoad: begin
                    if (tmr_last) begin
                        tmr_q      <= 8'd0;
                        cfg_load_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= StIdle;
                    end else begin
                        tmr_q <= tmr_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fw_read_data32   = rdata_q;
    assign fw_read_status32 = {cnt_q, 8'(wr_ptr_q), 5'd0, err_q, done_q, busy_q};
    assign fw_config_clk    = cfg_clk_q;
    assign fw_config_in     = cfg_in_q;
    assign fw_config_load   = cfg_load_q;

endmodule

// File: tb/tb_fw_ip2_cfg_shift_ctrl.sv
// Self-checking bench for fw_ip2_cfg_shift_ctrl with a cycle-formula reference model.
module tb_fw_ip2_cfg_shift_ctrl;

    localparam int W    = 32;
    localparam int MAXB = W * 24;

    logic        fw_clk_100 = 1'b0;
    logic        fw_rst = 1'b1;
    logic        op_code_w_reset = 1'b0;
    logic        op_code_w_cfg_static_0 = 1'b0;
    logic        op_code_r_cfg_static_0 = 1'b0;
    logic        op_code_w_cfg_array_0 = 1'b0;
    logic        op_code_r_cfg_array_0 = 1'b0;
    logic        op_code_w_execute = 1'b0;
    logic [23:0] sw_write24_0 = 24'd0;
    logic [31:0] fw_read_data32;
    logic [31:0] fw_read_status32;
    logic        fw_config_clk;
    logic        fw_config_in;
    logic        fw_config_load;
    logic        fw_config_out;

    fw_ip2_cfg_shift_ctrl #(.CFG_WORDS(W), .PTR_W(5)) dut (
        .fw_clk_100             (fw_clk_100),
        .fw_rst                 (fw_rst),
        .op_code_w_reset        (op_code_w_reset),
        .op_code_w_cfg_static_0 (op_code_w_cfg_static_0),
        .op_code_r_cfg_static_0 (op_code_r_cfg_static_0),
        .op_code_w_cfg_array_0  (op_code_w_cfg_array_0),
        .op_code_r_cfg_array_0  (op_code_r_cfg_array_0),
        .op_code_w_execute      (op_code_w_execute),
        .sw_write24_0           (sw_write24_0),
        .fw_read_data32         (fw_read_data32),
        .fw_read_status32       (fw_read_status32),
        .fw_config_clk          (fw_config_clk),
        .fw_config_in           (fw_config_in),
        .fw_config_load         (fw_config_load),
        .fw_config_out          (fw_config_out)
    );

    always #5 fw_clk_100 = ~fw_clk_100;

    // Chain return: either inverted data, or data delayed by one chain bit.
    logic mode_loop = 1'b0;
    logic loop_clr = 1'b0;
    logic loop_q = 1'b0;
    logic cfg_clk_d = 1'b0;
    always @(posedge fw_clk_100) begin
        cfg_clk_d <= fw_config_clk;
        if (loop_clr) loop_q <= 1'b0;
        else if (fw_config_clk && !cfg_clk_d) loop_q <= fw_config_in;
    end
    assign fw_config_out = mode_loop ? loop_q : ~fw_config_in;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [23:0] wmem [W];
    logic [23:0] rmem [W];
    logic [15:0] m_nbits;
    logic [7:0]  m_div;
    int          m_wr, m_rd, m_cnt;
    logic        m_done, m_err;
    logic [7:0]  first8;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge fw_clk_100);
        #1;
    endtask

    function automatic logic sbit(input int i);
        return wmem[i / 24][i % 24];
    endfunction

    function automatic logic [31:0] stat(input int cnt, input logic busy);
        return {16'(cnt), 8'(m_wr), 5'd0, m_err, m_done, busy};
    endfunction

    task automatic model_reset();
        m_nbits = 16'd0; m_div = 8'd1;
        m_wr = 0; m_rd = 0; m_cnt = 0; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_pins"}, 32'({fw_config_clk, fw_config_in, fw_config_load}), 32'd0);
        check_eq({tag, "_status"}, fw_read_status32, stat(m_cnt, 1'b0));
    endtask

    task automatic soft_reset(input string tag);
        op_code_w_reset = 1'b1; tick(); op_code_w_reset = 1'b0;
        model_reset();
        check_quiet(tag);
        check_eq({tag, "_rdata"}, fw_read_data32, 32'd0);
    endtask

    task automatic wr_static(input logic [23:0] v);
        sw_write24_0 = v; op_code_w_cfg_static_0 = 1'b1; tick(); op_code_w_cfg_static_0 = 1'b0;
        m_div = v[23:16]; m_nbits = v[15:0];
    endtask

    task automatic wr_array(input logic [23:0] v);
        sw_write24_0 = v; op_code_w_cfg_array_0 = 1'b1; tick(); op_code_w_cfg_array_0 = 1'b0;
        wmem[m_wr] = v; m_wr = (m_wr + 1) % W;
    endtask

    task automatic rd_static(input string tag);
        op_code_r_cfg_static_0 = 1'b1; tick(); op_code_r_cfg_static_0 = 1'b0;
        check_eq(tag, fw_read_data32, {8'h00, m_div, m_nbits});
    endtask

    task automatic rd_array(input string tag);
        op_code_r_cfg_array_0 = 1'b1; tick(); op_code_r_cfg_array_0 = 1'b0;
        check_eq(tag, fw_read_data32, {8'h00, rmem[m_rd]});
        m_rd = (m_rd + 1) % W;
    endtask

    // Execute and check every cycle against closed-form timing; optional busy-time
    // op-code injection (kind 0 = execute, 1 = array write) and mid-run soft reset.
    task automatic run_exec(input string name, input logic lp, input int inj_cycle,
                            input int inj_kind, input int rst_cycle);
        int d, n, total, ph, bi, e0, cnt;
        logic [2:0] pins;
        logic busy;
        bit ok;
        d = (m_div == 8'd0) ? 1 : int'(m_div);
        n = (int'(m_nbits) > MAXB) ? MAXB : int'(m_nbits);
        mode_loop = lp; loop_clr = 1'b1; op_code_w_execute = 1'b1;
        tick();
        op_code_w_execute = 1'b0; loop_clr = 1'b0;
        m_rd = 0;
        if (n == 0) begin
            m_done = 1'b1;
            check_quiet({name, "_nop"});
            return;
        end
        m_done = 1'b0;
        total = (2 * n + 1) * d;
        ok = 1'b1;
        for (int c = 1; c <= total + 1; c++) begin
            if (c <= 2 * n * d) begin
                ph = (c - 1) / d; bi = ph / 2;
                pins = {ph[0], sbit(bi), 1'b0}; busy = 1'b1; cnt = bi;
                if (ph % 2 == 1 && (c - 1) % d == 0)
                    rmem[bi / 24][bi % 24] = lp ? ((bi == 0) ? 1'b0 : sbit(bi - 1)) : ~sbit(bi);
                if (bi < 8 && ph % 2 == 0 && (c - 1) % d == 0) first8[bi] = fw_config_in;
            end else if (c <= total) begin
                pins = 3'b001; busy = 1'b1; cnt = n - 1;
            end else begin
                pins = 3'b000; busy = 1'b0; cnt = n - 1; m_done = 1'b1; m_cnt = n - 1;
            end
            if (ok) begin
                e0 = errors;
                check_eq($sformatf("%s_c%0d_pins", name, c),
                         32'({fw_config_clk, fw_config_in, fw_config_load}), 32'(pins));
                check_eq($sformatf("%s_c%0d_status", name, c), fw_read_status32, stat(cnt, busy));
                if (errors != e0) ok = 1'b0;
            end
            if (c == rst_cycle) begin
                soft_reset({name, "_midreset"});
                return;
            end
            if (c == inj_cycle) begin
                if (inj_kind == 0) op_code_w_execute = 1'b1;
                else begin
                    sw_write24_0 = 24'($urandom);
                    op_code_w_cfg_array_0 = 1'b1;
                end
            end
            if (c <= total) begin
                tick();
                op_code_w_execute = 1'b0; op_code_w_cfg_array_0 = 1'b0;
                if (c == inj_cycle) m_err = 1'b1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        first8 = 8'd0;
        // Hardware reset, then idle state and default static register.
        tick(); tick();
        fw_rst = 1'b0;
        tick();
        check_quiet("reset");
        check_eq("reset_rdata", fw_read_data32, 32'd0);
        rd_static("reset_static");
        check_eq("reset_static_const", fw_read_data32, 32'h0001_0000);

        // 33 writes: pointer wraps to 1, word 0 overwritten.
        for (int i = 0; i < 33; i++) wr_array(24'($urandom));
        check_eq("wrap_status", fw_read_status32, stat(m_cnt, 1'b0));
        check_eq("wrap_wr_ptr", 32'(fw_read_status32[15:8]), 32'h01);

        // NBITS clamp to the full chain and DIV=0 treated as 1; fills the readback.
        wr_static(24'h00_FFFF);
        rd_static("clamp_static");
        run_exec("clamp", 1'b0, -1, 0, -1);
        for (int i = 0; i < W; i++) rd_array($sformatf("clamp_rb%0d", i));

        // A5A5A5 / 3C3C3C with DIV=2, NBITS=48.
        soft_reset("sr1");
        wr_array(24'hA5A5A5);
        wr_array(24'h3C3C3C);
        wr_static(24'h02_0030);
        run_exec("a5", 1'b0, -1, 0, -1);
        check_eq("a5_first8", 32'(first8), 32'h0000_00A5);
        rd_array("a5_rb0");
        rd_array("a5_rb1");

        // One-bit-delayed loopback.
        soft_reset("sr2");
        wr_array(24'h000001);
        wr_static(24'h01_0018);
        run_exec("loop", 1'b1, -1, 0, -1);
        rd_array("loop_rb0");
        check_eq("loop_rb0_const", fw_read_data32, 32'h0000_0002);

        // Randomised runs, two with op-codes injected while busy.
        for (int r = 0; r < 6; r++) begin
            int k;
            k = int'($urandom_range(1, 4));
            for (int i = 0; i < k; i++) wr_array(24'($urandom));
            wr_static({8'($urandom_range(0, 3)), 16'($urandom_range(4, 80))});
            run_exec($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)),
                     (r == 4) ? 5 : ((r == 5) ? 7 : -1), (r == 4) ? 0 : 1, -1);
            for (int i = 0; i < 3; i++) rd_array($sformatf("rnd%0d_rb%0d", r, i));
        end
        check_eq("err_sticky", 32'(fw_read_status32[2]), 32'd1);
        soft_reset("sr3");

        // Soft reset in the second cycle of bit 1's high phase.
        wr_static(24'h03_000A);
        run_exec("midrst", 1'b0, -1, 0, 11);
        rd_static("midrst_static");
        rd_array("midrst_rb0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
